alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/riscv_pkg.sv | 17 +
 rtl/alu_arbiter_if.sv | 20 ++
 rtl/alu.sv | 25 ++
 rtl/alu_arbiter.sv | 61 ++++++
 tb/tb_alu_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared ALU types and arbiter limits
package riscv_pkg;
    localparam int ALU_NUM_REQ_MAX = 4;
    typedef logic [31:0] word_t;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bundle between requesters and the shared ALU
interface alu_arbiter_if import riscv_pkg::*; #(parameter int NUM_REQ = 2);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    alu_op_t            req_op [NUM_REQ];
    word_t              req_a  [NUM_REQ];
    word_t              req_b  [NUM_REQ];
    logic [NUM_REQ-1:0] rsp_valid;
    logic [NUM_REQ-1:0] rsp_ready;
    word_t              rsp_result;
    logic               rsp_zero;
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero
    );
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu.sv
// alu: combinational RV32 integer ALU, undefined ops yield zero
module alu import riscv_pkg::*; (
    input  alu_op_t op,
    input  word_t   a,
    input  word_t   b,
    output word_t   result,
    output logic    zero
);
    always_comb begin
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = word_t'($signed(a) >>> b[4:0]);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end
    assign zero = result == '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU with a single registered response slot
module alu_arbiter import riscv_pkg::*; #(parameter int NUM_REQ = 2) (
    input logic         clk,
    input logic         rst_n,
    alu_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    if (NUM_REQ < 2 || NUM_REQ > ALU_NUM_REQ_MAX) begin : g_bad_num_req
        $error("alu_arbiter: NUM_REQ out of range");
    end
    logic [IW-1:0] last_q, owner_q, win, idx;
    logic          rsp_v_q, zero_q, found, drain, accept, alu_zero;
    word_t         result_q, alu_res, alu_a, alu_b;
    alu_op_t       alu_op;
    logic [31:0]   busy_cycles;
    // highest-priority candidate is visited last so it overrides earlier hits
    always_comb begin
        win = '0;
        idx = '0;
        found = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(last_q) + k) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                win = idx;
                found = 1'b1;
            end
        end
    end
    assign drain  = rsp_v_q & bus.rsp_ready[owner_q];
    assign accept = rst_n & found & (~rsp_v_q | drain);
    assign alu_op = accept ? bus.req_op[win] : ALU_ADD;
    assign alu_a  = accept ? bus.req_a[win] : '0;
    assign alu_b  = accept ? bus.req_b[win] : '0;
    alu u_alu (.op(alu_op), .a(alu_a), .b(alu_b), .result(alu_res), .zero(alu_zero));
    assign bus.req_ready  = {NUM_REQ{accept}} & (NUM_REQ'(1) << win);
    assign bus.rsp_valid  = {NUM_REQ{rsp_v_q}} & (NUM_REQ'(1) << owner_q);
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_v_q     <= 1'b0;
            owner_q     <= '0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            last_q      <= IW'(NUM_REQ - 1);
            busy_cycles <= '0;
        end else begin
            if (accept) begin
                rsp_v_q  <= 1'b1;
                owner_q  <= win;
                last_q   <= win;
                result_q <= alu_res;
                zero_q   <= alu_zero;
            end else if (drain) begin
                rsp_v_q <= 1'b0;
            end
            if (|bus.req_valid && !accept && busy_cycles != '1)
                busy_cycles <= busy_cycles + 32'd1;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
    import riscv_pkg::*;
    localparam int N = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    alu_arbiter_if #(.NUM_REQ(N)) bus ();
    alu_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int compared = 0;
    int mismatched = 0;
    int          m_last, m_owner;
    bit          m_pend, m_zero;
    word_t       m_res;
    logic [31:0] m_busy;

    function automatic word_t ref_alu(logic [3:0] op, word_t a, word_t b);
        int unsigned sh = b[4:0];
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << sh;
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return word_t'($signed(a) >>> sh);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic int m_grant();
        int w = -1;
        if (m_pend && !bus.rsp_ready[m_owner]) return -1;
        for (int k = 1; k <= N; k++)
            if (w < 0 && bus.req_valid[(m_last + k) % N]) w = (m_last + k) % N;
        return w;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int w = m_grant();
        return (w < 0) ? '0 : N'(1) << w;
    endfunction

    task automatic m_reset();
        m_last = N - 1; m_owner = 0; m_pend = 0; m_zero = 0; m_res = '0; m_busy = '0;
    endtask

    task automatic tick();
        int w = m_grant();
        if (w >= 0) begin
            m_res = ref_alu(bus.req_op[w], bus.req_a[w], bus.req_b[w]);
            m_zero = (m_res == 0);
            m_pend = 1; m_owner = w; m_last = w;
        end else begin
            if (m_pend && bus.rsp_ready[m_owner]) m_pend = 0;
            if (|bus.req_valid && m_busy != 32'hFFFF_FFFF) m_busy = m_busy + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = '1; bus.rsp_ready = '1;
        for (int i = 0; i < N; i++) begin
            bus.req_op[i] = ALU_ADD; bus.req_a[i] = 32'd1; bus.req_b[i] = 32'd2;
        end
        m_reset();
        #2;
        compared++;
        if (bus.rsp_valid !== '0 || bus.req_ready !== '0) begin
            mismatched++;
            $display("FAIL reset_hs rsp_valid=%b req_ready=%b, required 0/0", bus.rsp_valid, bus.req_ready);
        end
        compared++;
        if (bus.rsp_result !== '0 || bus.rsp_zero !== 1'b0 || dut.busy_cycles !== '0) begin
            mismatched++;
            $display("FAIL reset_regs result=%h zero=%b busy=%0d, required 0/0/0", bus.rsp_result, bus.rsp_zero, dut.busy_cycles);
        end
        bus.req_valid = '0;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bus.req_valid = 2'b11; bus.rsp_ready = 2'b11;
        bus.req_op[0] = ALU_ADD; bus.req_a[0] = 32'd5;  bus.req_b[0] = 32'd7;
        bus.req_op[1] = ALU_SUB; bus.req_a[1] = 32'd10; bus.req_b[1] = 32'd3;
        #1;
        compared++;
        if (bus.req_ready !== 2'b01) begin
            mismatched++;
            $display("FAIL basic_grant0 req_ready=%b, required 01", bus.req_ready);
        end
        tick();
        compared++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'd12 || bus.req_ready !== 2'b10) begin
            mismatched++;
            $display("FAIL basic_rsp0 rsp_valid=%b result=%0d req_ready=%b, required 01/12/10", bus.rsp_valid, bus.rsp_result, bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        #1;
        compared++;
        if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 32'd7 || bus.rsp_zero !== 1'b0) begin
            mismatched++;
            $display("FAIL basic_rsp1 rsp_valid=%b result=%0d zero=%b, required 10/7/0", bus.rsp_valid, bus.rsp_result, bus.rsp_zero);
        end
        tick();
        compared++;
        if (bus.rsp_valid !== 2'b00) begin
            mismatched++;
            $display("FAIL basic_drain rsp_valid=%b, required 00", bus.rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] b0;
        bus.req_valid = 2'b01; bus.rsp_ready = 2'b00;
        bus.req_op[0] = ALU_SUB; bus.req_a[0] = 32'd9; bus.req_b[0] = 32'd9;
        #1;
        compared++;
        if (bus.req_ready !== 2'b01) begin
            mismatched++;
            $display("FAIL bp_accept req_ready=%b, required 01", bus.req_ready);
        end
        tick();
        b0 = m_busy;
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'd0 || bus.rsp_zero !== 1'b1 || bus.req_ready !== 2'b00) begin
                mismatched++;
                $display("FAIL bp_hold[%0d] rsp_valid=%b result=%h zero=%b req_ready=%b, required 01/0/1/00", i, bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.req_ready);
            end
            compared++;
            if (dut.busy_cycles !== b0 + 32'(i)) begin
                mismatched++;
                $display("FAIL bp_busy[%0d] busy=%0d, required %0d", i, dut.busy_cycles, b0 + 32'(i));
            end
            tick();
        end
        bus.rsp_ready = 2'b01;
        #1;
        compared++;
        if (dut.busy_cycles !== b0 + 32'd3 || bus.req_ready !== 2'b01) begin
            mismatched++;
            $display("FAIL bp_release busy=%0d req_ready=%b, required %0d/01", dut.busy_cycles, bus.req_ready, b0 + 32'd3);
        end
        tick();
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_alternate();
        logic [N-1:0] prev = '0;
        int responses = 0;
        bus.req_valid = 2'b11; bus.rsp_ready = 2'b11;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) begin
                bus.req_op[i] = alu_op_t'(4'($urandom_range(0, 9)));
                bus.req_a[i] = $urandom; bus.req_b[i] = $urandom;
            end
            #1;
            compared++;
            if (bus.req_ready !== m_ready() || (c > 0 && bus.req_ready === prev)) begin
                mismatched++;
                $display("FAIL alt_grant[%0d] req_ready=%b, required %b (previous %b)", c, bus.req_ready, m_ready(), prev);
            end
            prev = bus.req_ready;
            tick();
            if (bus.rsp_valid !== '0) responses++;
            compared++;
            if (bus.rsp_result !== m_res) begin
                mismatched++;
                $display("FAIL alt_result[%0d] result=%h, required %h", c, bus.rsp_result, m_res);
            end
        end
        compared++;
        if (responses != 8) begin
            mismatched++;
            $display("FAIL alt_count responses=%0d, required 8", responses);
        end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_ops();
        alu_op_t ops [4];
        word_t   av [4], bv [4], ev [4];
        int      who [4];
        ops[0] = ALU_SRA;  av[0] = 32'h8000_0000; bv[0] = 32'd4; ev[0] = 32'hF800_0000; who[0] = 0;
        ops[1] = ALU_SLT;  av[1] = 32'hFFFF_FFFF; bv[1] = 32'd1; ev[1] = 32'd1;         who[1] = 0;
        ops[2] = ALU_SLTU; av[2] = 32'hFFFF_FFFF; bv[2] = 32'd1; ev[2] = 32'd0;         who[2] = 0;
        ops[3] = alu_op_t'(4'hC); av[3] = 32'h1234_5678; bv[3] = 32'h0000_0011; ev[3] = 32'd0; who[3] = 1;
        bus.rsp_ready = '1;
        for (int t = 0; t < 4; t++) begin
            bus.req_valid = N'(1) << who[t];
            bus.req_op[who[t]] = ops[t]; bus.req_a[who[t]] = av[t]; bus.req_b[who[t]] = bv[t];
            #1;
            tick();
            bus.req_valid = '0;
            #1;
            compared++;
            if (bus.rsp_valid !== N'(1) << who[t] || bus.rsp_result !== ev[t] || bus.rsp_zero !== (ev[t] == 0)) begin
                mismatched++;
                $display("FAIL op[%0d] rsp_valid=%b result=%h zero=%b, required %b/%h/%b", t, bus.rsp_valid, bus.rsp_result, bus.rsp_zero, N'(1) << who[t], ev[t], ev[t] == 0);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        bus.req_valid = 2'b10; bus.rsp_ready = 2'b00;
        bus.req_op[1] = ALU_ADD; bus.req_a[1] = $urandom; bus.req_b[1] = 32'd1;
        #1;
        tick();
        bus.req_valid = '0;
        #1;
        compared++;
        if (bus.rsp_valid !== 2'b10) begin
            mismatched++;
            $display("FAIL rmid_pending rsp_valid=%b, required 10", bus.rsp_valid);
        end
        #1 rst_n = 1'b0;
        m_reset();
        #1;
        compared++;
        if (bus.rsp_valid !== 2'b00 || bus.rsp_result !== '0 || bus.req_ready !== '0) begin
            mismatched++;
            $display("FAIL rmid_async rsp_valid=%b result=%h req_ready=%b, required 00/0/00", bus.rsp_valid, bus.rsp_result, bus.req_ready);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        bus.req_valid = 2'b11; bus.rsp_ready = 2'b11;
        bus.req_op[0] = ALU_XOR; bus.req_a[0] = 32'hF0F0_F0F0; bus.req_b[0] = 32'h0F0F_0F0F;
        #1;
        compared++;
        if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b01) begin
            mismatched++;
            $display("FAIL rmid_after rsp_valid=%b req_ready=%b, required 00/01", bus.rsp_valid, bus.req_ready);
        end
        tick();
        compared++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'hFFFF_FFFF) begin
            mismatched++;
            $display("FAIL rmid_first rsp_valid=%b result=%h, required 01/ffffffff", bus.rsp_valid, bus.rsp_result);
        end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] ev;
        for (int c = 0; c < 400; c++) begin
            bus.req_valid = N'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            for (int i = 0; i < N; i++) begin
                bus.req_op[i] = alu_op_t'(4'($urandom_range(0, 15)));
                bus.req_a[i] = $urandom;
                bus.req_b[i] = ($urandom_range(0, 3) == 0) ? bus.req_a[i] : $urandom;
            end
            #1;
            ev = m_pend ? N'(1) << m_owner : '0;
            compared++;
            if (bus.req_ready !== m_ready() || bus.rsp_valid !== ev) begin
                mismatched++;
                $display("FAIL rand_hs[%0d] req_ready=%b rsp_valid=%b, required %b/%b", c, bus.req_ready, bus.rsp_valid, m_ready(), ev);
            end
            compared++;
            if (bus.rsp_result !== m_res || bus.rsp_zero !== m_zero || dut.busy_cycles !== m_busy) begin
                mismatched++;
                $display("FAIL rand_data[%0d] result=%h zero=%b busy=%0d, required %h/%b/%0d", c, bus.rsp_result, bus.rsp_zero, dut.busy_cycles, m_res, m_zero, m_busy);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_alternate();
        test_ops();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
